// File: rtl/pwm_csr_multi_if.sv
// pwm_csr_multi_if: Avalon-MM-style slave bus bundle for the PWM CSR block
interface pwm_csr_multi_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              chipselect;
  logic              write;
  logic              read;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  modport master (
    output chipselect, write, read, address, writedata,
    input  readdata, readdatavalid
  );
  modport slave (
    input  chipselect, write, read, address, writedata,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/pwm_csr_multi.sv
// pwm_csr_multi: per-channel PWM shadow/active CSRs committed at period boundaries,
// sticky masked period-end interrupts and a one-cycle registered read path
module pwm_csr_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  pwm_csr_multi_if.slave          bus,
  output logic [NUM_CH-1:0]       enable,
  output logic [NUM_CH*CNT_W-1:0] period,
  output logic [NUM_CH*CNT_W-1:0] duty_cycle,
  output logic [NUM_CH*CNT_W-1:0] divisor,
  input  logic [NUM_CH-1:0]       pwm_running,
  input  logic [NUM_CH-1:0]       period_end,
  output logic                    irq
);
  logic              wr, rd, rvalid_q, irq_q, unused_wd;
  logic [31:0]       a;
  logic [NUM_CH-1:0] ctrl, irq_pend, irq_mask, pend, load, sel_com, w1c, wd_ch;
  logic [CNT_W-1:0]  wd_cnt, wd_div;
  logic [CNT_W-1:0]  sh_per [NUM_CH];
  logic [CNT_W-1:0]  sh_duty [NUM_CH];
  logic [CNT_W-1:0]  sh_div [NUM_CH];
  logic [CNT_W-1:0]  act_per [NUM_CH];
  logic [CNT_W-1:0]  act_duty [NUM_CH];
  logic [CNT_W-1:0]  act_div [NUM_CH];
  logic [DATA_W-1:0] rdata, rdata_q;

  assign wr        = bus.chipselect & bus.write;
  assign rd        = bus.chipselect & bus.read;
  assign a         = 32'(bus.address);
  assign wd_ch     = bus.writedata[NUM_CH-1:0];
  assign wd_cnt    = bus.writedata[CNT_W-1:0];
  assign wd_div    = (wd_cnt == '0) ? CNT_W'(1) : wd_cnt;
  assign unused_wd = ^bus.writedata;
  assign w1c       = (wr && a == 32'd2) ? wd_ch : '0;
  // a disabled channel has no period to wait for, so its commit lands immediately
  assign load      = pend & (~ctrl | period_end);

  assign enable            = ctrl;
  assign irq               = irq_q;
  assign bus.readdata      = rdata_q;
  assign bus.readdatavalid = rvalid_q;

  always_comb begin
    sel_com = '0;
    for (int i = 0; i < NUM_CH; i++) sel_com[i] = wr && a == 32'(7 + 4 * i);
  end

  always_comb begin
    rdata = a == 32'd0 ? DATA_W'(ctrl) :
            a == 32'd1 ? DATA_W'(pwm_running) :
            a == 32'd2 ? DATA_W'(irq_pend) :
            a == 32'd3 ? DATA_W'(irq_mask) : '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (a == 32'(4 + 4 * i)) rdata = DATA_W'(sh_per[i]);
      if (a == 32'(5 + 4 * i)) rdata = DATA_W'(sh_duty[i]);
      if (a == 32'(6 + 4 * i)) rdata = DATA_W'(sh_div[i]);
      if (a == 32'(7 + 4 * i)) rdata = DATA_W'(pend[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl     <= '0;
      irq_pend <= '0;
      irq_mask <= '0;
      pend     <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        sh_per[i]   <= '0;
        sh_duty[i]  <= '0;
        sh_div[i]   <= CNT_W'(1);
        act_per[i]  <= '0;
        act_duty[i] <= '0;
        act_div[i]  <= CNT_W'(1);
      end
    end else begin
      rvalid_q <= rd;
      if (rd) rdata_q <= rdata;
      irq_q <= |(irq_pend & irq_mask);
      if (wr && a == 32'd0) ctrl <= wd_ch;
      if (wr && a == 32'd3) irq_mask <= wd_ch;
      irq_pend <= (irq_pend & ~w1c) | (period_end & ctrl);
      // a fresh commit re-arms even when a load consumes the previous one
      pend <= sel_com | (pend & ~load);
      for (int i = 0; i < NUM_CH; i++) begin
        if (load[i]) begin
          act_per[i]  <= sh_per[i];
          act_duty[i] <= sh_duty[i];
          act_div[i]  <= sh_div[i];
        end
        if (wr && a == 32'(4 + 4 * i)) sh_per[i] <= wd_cnt;
        if (wr && a == 32'(5 + 4 * i)) sh_duty[i] <= wd_cnt;
        if (wr && a == 32'(6 + 4 * i)) sh_div[i] <= wd_div;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_out
    assign period[c*CNT_W +: CNT_W]     = act_per[c];
    assign duty_cycle[c*CNT_W +: CNT_W] = act_duty[c];
    assign divisor[c*CNT_W +: CNT_W]    = act_div[c];
  end
endmodule

// File: tb/tb_pwm_csr_multi.sv
// tb_pwm_csr_multi: directed and randomized scoreboard bench for pwm_csr_multi,
// checked against a register-map model of the CSR block
module tb_pwm_csr_multi;
  localparam int NC = 4;
  localparam int CW = 16;
  localparam int DW = 32;
  localparam int AW = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NC-1:0]     enable;
  logic [NC-1:0]     pwm_running = '0;
  logic [NC-1:0]     period_end = '0;
  logic [NC*CW-1:0]  period, duty_cycle, divisor;
  logic              irq;

  pwm_csr_multi_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  pwm_csr_multi #(.NUM_CH(NC), .CNT_W(CW), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .enable(enable),
    .period(period),
    .duty_cycle(duty_cycle),
    .divisor(divisor),
    .pwm_running(pwm_running),
    .period_end(period_end),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_q [$];

  // model: index 0 = period, 1 = duty, 2 = divisor
  bit [CW-1:0] m_sh  [3][NC];
  bit [CW-1:0] m_act [3][NC];
  bit [NC-1:0] m_ctrl, m_mask, m_ipend, m_pend;
  bit          m_irq, m_rv;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset && bus.readdatavalid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_readdatavalid: got data 0x%0h with no read outstanding", bus.readdata);
      end else chk("readdata", 64'(bus.readdata), 64'(exp_q.pop_front()));
    end
  end

  function automatic void m_reset();
    for (int c = 0; c < NC; c++) begin
      for (int k = 0; k < 3; k++) begin
        m_sh[k][c]  = (k == 2) ? CW'(1) : CW'(0);
        m_act[k][c] = (k == 2) ? CW'(1) : CW'(0);
      end
    end
    m_ctrl = '0; m_mask = '0; m_ipend = '0; m_pend = '0; m_irq = 1'b0; m_rv = 1'b0;
  endfunction

  function automatic logic [DW-1:0] m_read(input int adr);
    int c, k;
    c = (adr - 4) / 4;
    k = (adr - 4) % 4;
    if (adr == 0) return DW'(m_ctrl);
    if (adr == 1) return DW'(pwm_running);
    if (adr == 2) return DW'(m_ipend);
    if (adr == 3) return DW'(m_mask);
    if (adr >= 4 && adr < 4 + 4 * NC) return (k == 3) ? DW'(m_pend[c]) : DW'(m_sh[k][c]);
    return '0;
  endfunction

  function automatic void m_update(input bit we, input bit re, input int adr,
                                   input logic [DW-1:0] wd, input logic [NC-1:0] pe);
    bit [NC-1:0] ld, clr;
    int c, k;
    ld    = m_pend & (~m_ctrl | pe);
    clr   = (we && adr == 2) ? wd[NC-1:0] : '0;
    m_rv  = re;
    m_irq = |(m_ipend & m_mask);
    m_ipend = (m_ipend & ~clr) | (pe & m_ctrl);
    for (int i = 0; i < NC; i++) begin
      if (ld[i]) begin
        for (int j = 0; j < 3; j++) m_act[j][i] = m_sh[j][i];
        m_pend[i] = 1'b0;
      end
    end
    if (we) begin
      if (adr == 0) m_ctrl = wd[NC-1:0];
      if (adr == 3) m_mask = wd[NC-1:0];
      if (adr >= 4 && adr < 4 + 4 * NC) begin
        c = (adr - 4) / 4;
        k = (adr - 4) % 4;
        if (k == 3) m_pend[c] = 1'b1;
        else m_sh[k][c] = (k == 2 && wd[CW-1:0] == '0) ? CW'(1) : wd[CW-1:0];
      end
    end
  endfunction

  function automatic logic [NC*CW-1:0] pack(input int k);
    logic [NC*CW-1:0] v;
    for (int c = 0; c < NC; c++) v[c*CW +: CW] = m_act[k][c];
    return v;
  endfunction

  task automatic check_outs();
    chk("enable", 64'(enable), 64'(m_ctrl));
    chk("period", 64'(period), 64'(pack(0)));
    chk("duty_cycle", 64'(duty_cycle), 64'(pack(1)));
    chk("divisor", 64'(divisor), 64'(pack(2)));
    chk("irq", 64'(irq), 64'(m_irq));
    chk("readdatavalid", 64'(bus.readdatavalid), 64'(m_rv));
  endtask

  task automatic step(input bit cs, input bit we, input bit re, input int adr,
                      input logic [DW-1:0] wd, input logic [NC-1:0] pe);
    bus.chipselect = cs;
    bus.write      = we;
    bus.read       = re;
    bus.address    = AW'(adr);
    bus.writedata  = wd;
    period_end     = pe;
    if (cs && re) exp_q.push_back(m_read(adr));
    m_update(cs && we, cs && re, adr, wd, pe);
    @(negedge clk);
    check_outs();
  endtask

  task automatic wr_reg(input int adr, input logic [DW-1:0] wd);
    step(1'b1, 1'b1, 1'b0, adr, wd, '0);
  endtask

  task automatic rd_reg(input int adr);
    step(1'b1, 1'b0, 1'b1, adr, '0, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, '0, '0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_enable"}, 64'(enable), 64'h0);
    chk({tag, "_period"}, 64'(period), 64'h0);
    chk({tag, "_duty"}, 64'(duty_cycle), 64'h0);
    chk({tag, "_divisor"}, 64'(divisor), 64'h0001_0001_0001_0001);
    chk({tag, "_irq"}, 64'(irq), 64'h0);
    chk({tag, "_readdatavalid"}, 64'(bus.readdatavalid), 64'h0);
    chk({tag, "_readdata"}, 64'(bus.readdata), 64'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] wd;
    int adr;
    bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
    bus.address = '0; bus.writedata = '0;
    m_reset();
    #1 reset = 1'b0;
    #11;
    chk_reset_outs("por");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // channel 1 commit waits for its period boundary
    wr_reg(0, 32'h2);
    wr_reg(8, 32'hFFFF_0100);
    wr_reg(9, 128);
    wr_reg(11, 32'hDEAD);
    idle(3);
    chk("ch1_hold_period", 64'(period[31:16]), 64'd0);
    step(1'b0, 1'b0, 1'b0, 0, '0, 4'b0010);
    chk("ch1_period", 64'(period[31:16]), 64'd256);
    chk("ch1_duty", 64'(duty_cycle[31:16]), 64'd128);
    rd_reg(11);

    // channel 0 disabled: commit lands the cycle after pend is set; divisor 0 stores 1
    wr_reg(6, 5);
    wr_reg(7, 0);
    idle(1);
    chk("ch0_div5", 64'(divisor[15:0]), 64'd5);
    wr_reg(6, 0);
    wr_reg(7, 1);
    chk("ch0_div_hold", 64'(divisor[15:0]), 64'd5);
    idle(1);
    chk("ch0_div_zero_is_one", 64'(divisor[15:0]), 64'd1);

    // sticky masked interrupt with set-over-clear
    wr_reg(2, 32'hF);
    wr_reg(3, 4);
    wr_reg(0, 6);
    step(1'b0, 1'b0, 1'b0, 0, '0, 4'b0100);
    rd_reg(2);
    chk("irq_set", 64'(irq), 64'd1);
    step(1'b1, 1'b1, 1'b0, 2, 32'h4, 4'b0100);
    rd_reg(2);
    wr_reg(2, 32'h4);
    chk("irq_lag", 64'(irq), 64'd1);
    idle(1);
    chk("irq_clear", 64'(irq), 64'd0);
    idle(1);

    // back-to-back reads: status, unmapped, commit registers
    pwm_running = 4'b1010;
    wr_reg(15, 0);
    rd_reg(1);
    rd_reg(31);
    rd_reg(15);
    rd_reg(11);
    idle(1);

    // same-cycle read/write returns pre-write value; commit during load keeps pend
    step(1'b1, 1'b1, 1'b1, 12, 32'h1234, '0);
    rd_reg(12);
    step(1'b1, 1'b1, 1'b0, 15, '0, 4'b0100);
    rd_reg(15);
    step(1'b1, 1'b1, 1'b0, 11, '0, 4'b0010);
    idle(2);
    step(1'b1, 1'b1, 1'b0, 8, 777, 4'b0010);
    chk("shadow_write_during_load", 64'(period[31:16]), 64'd256);
    wr_reg(11, 0);

    // asynchronous reset in the middle of a read
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.write = 1'b0; bus.address = AW'(1);
    @(posedge clk);
    #1;
    chk("rdv_before_reset", 64'(bus.readdatavalid), 64'd1);
    reset = 1'b0;
    #1;
    chk_reset_outs("mid");
    bus.chipselect = 1'b0; bus.read = 1'b0;
    m_reset();
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rd_reg(11);
    rd_reg(0);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      wd  = $urandom;
      adr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 19));
      if ($urandom_range(0, 3) == 0) wd[CW-1:0] = '0;
      pwm_running = NC'($urandom);
      step($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           adr, wd, NC'($urandom) & NC'($urandom));
    end

    idle(3);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
